// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the serial parity checker: FSM state encoding and
// a small decode helper used by the top-level control.
package serial_parity_checker_pkg;

  // 2'd3 is never entered; the control logic treats it exactly like IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  // True while a frame is in flight (data bits or the trailing parity bit).
  function automatic logic frame_active(input state_t s);
    return (s == ST_DATA) || (s == ST_PAR);
  endfunction

endpackage

// File: rtl/serial_parity_checker_parity_lane.sv
// One serial lane: running XOR of the data bits and the registered parity
// check result. Timing (load/accumulate/check) comes from the shared FSM.
module parity_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic acc,
  input  logic chk,
  input  logic mode,
  input  logic x,
  output logic z,
  output logic parity_err
);

  logic z_q, z_d;
  logic err_q, err_d;

  // Next-state: load restarts the XOR, acc folds in a bit, chk compares parity.
  always_comb begin
    z_d   = z_q;
    err_d = err_q;
    if (load) begin
      z_d = x;
    end else if (acc) begin
      z_d = z_q ^ x;
    end
    if (chk) begin
      err_d = z_q ^ x ^ mode;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      err_q <= err_d;
    end
  end

  assign z          = z_q;
  assign parity_err = err_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Multi-lane framed serial parity checker. A single control FSM and bit
// counter sequence FRAME_LEN data bits plus one parity bit; each lane keeps
// its own XOR accumulator and error flag.
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter  int CHANNELS  = 1,
  parameter  int FRAME_LEN = 8,
  localparam int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                start,
  input  logic                odd_mode,
  input  logic [CHANNELS-1:0] x,
  output logic [CHANNELS-1:0] z,
  output logic [CW-1:0]       bit_cnt,
  output logic                busy,
  output logic                frame_done,
  output logic [CHANNELS-1:0] parity_err,
  output logic                frame_abort
);

  localparam logic [CW-1:0] LAST_DATA = CW'(FRAME_LEN - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic            lane_load, lane_acc, lane_chk;

  // Control next-state: start always wins and opens a new frame; otherwise
  // DATA counts bits and PAR performs the check. en low freezes everything,
  // while the done/abort pulses default back to zero every cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    lane_load = 1'b0;
    lane_acc  = 1'b0;
    lane_chk  = 1'b0;
    if (en) begin
      if (start) begin
        lane_load = 1'b1;
        cnt_d     = CW'(1);
        mode_d    = odd_mode;
        state_d   = (FRAME_LEN == 1) ? ST_PAR : ST_DATA;
        abort_d   = frame_active(state_q);
      end else begin
        case (state_q)
          ST_DATA: begin
            lane_acc = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_DATA) begin
              state_d = ST_PAR;
            end
          end
          ST_PAR: begin
            lane_chk = 1'b1;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    parity_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (lane_load),
      .acc        (lane_acc),
      .chk        (lane_chk),
      .mode       (mode_q),
      .x          (x[g]),
      .z          (z[g]),
      .parity_err (parity_err[g])
    );
  end

  assign bit_cnt     = cnt_q;
  assign busy        = frame_active(state_q);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
module tb_serial_parity_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // DUT A: CHANNELS=2, FRAME_LEN=4
  logic       rst_n, en, start, odd_mode;
  logic [1:0] x, z, perr;
  logic [2:0] bit_cnt;
  logic       busy, done, abort;

  serial_parity_checker #(.CHANNELS(2), .FRAME_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .odd_mode(odd_mode),
    .x(x), .z(z), .bit_cnt(bit_cnt), .busy(busy), .frame_done(done),
    .parity_err(perr), .frame_abort(abort)
  );

  // DUT B: CHANNELS=2, FRAME_LEN=1
  logic       en2, start2, odd2;
  logic [1:0] x2, z2, perr2;
  logic [0:0] bit_cnt2;
  logic       busy2, done2, abort2;

  serial_parity_checker #(.CHANNELS(2), .FRAME_LEN(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .start(start2), .odd_mode(odd2),
    .x(x2), .z(z2), .bit_cnt(bit_cnt2), .busy(busy2), .frame_done(done2),
    .parity_err(perr2), .frame_abort(abort2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [1:0] xv);
    en = 1'b1; start = s; x = xv;
    tick();
    en = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; start = 0; odd_mode = 0; x = 0;
    en2 = 0; start2 = 0; odd2 = 0; x2 = 0;
    #12;
    vecs++;
    if ({z, bit_cnt, busy, done, perr, abort} !== 10'd0) begin
      errs++; $display("FAIL reset_outputs got %b want 0", {z, bit_cnt, busy, done, perr, abort});
    end
    rst_n = 1'b1;
    tick(); tick();
    vecs++;
    if ({z, bit_cnt, busy, done, perr, abort} !== 10'd0) begin
      errs++; $display("FAIL idle_after_reset got %b want 0", {z, bit_cnt, busy, done, perr, abort});
    end
  endtask

  task automatic test_even();
    odd_mode = 1'b0;
    send(1, 2'b01);
    vecs++;
    if ({busy, bit_cnt, z} !== {1'b1, 3'd1, 2'b01}) begin
      errs++; $display("FAIL even_first_bit got busy=%b cnt=%0d z=%b want 1 1 01", busy, bit_cnt, z);
    end
    send(0, 2'b00); send(0, 2'b01); send(0, 2'b01);
    vecs++;
    if ({bit_cnt, z, done} !== {3'd4, 2'b01, 1'b0}) begin
      errs++; $display("FAIL even_after_data got cnt=%0d z=%b done=%b want 4 01 0", bit_cnt, z, done);
    end
    send(0, 2'b01);
    vecs++;
    if ({done, perr, z, bit_cnt, busy} !== {1'b1, 2'b00, 2'b01, 3'd4, 1'b0}) begin
      errs++; $display("FAIL even_check got done=%b err=%b z=%b cnt=%0d busy=%b want 1 00 01 4 0", done, perr, z, bit_cnt, busy);
    end
    tick();
    vecs++;
    if ({done, perr} !== {1'b0, 2'b00}) begin
      errs++; $display("FAIL even_done_clear got done=%b err=%b want 0 00", done, perr);
    end
  endtask

  task automatic test_odd();
    odd_mode = 1'b1;
    send(1, 2'b01);
    odd_mode = 1'b0;
    send(0, 2'b00);
    odd_mode = 1'b1;
    send(0, 2'b01);
    odd_mode = 1'b0;
    send(0, 2'b01);
    send(0, 2'b01);
    vecs++;
    if ({done, perr, abort} !== {1'b1, 2'b11, 1'b0}) begin
      errs++; $display("FAIL odd_check got done=%b err=%b abort=%b want 1 11 0", done, perr, abort);
    end
    tick();
  endtask

  task automatic test_en_hold();
    int ndone = 0;
    odd_mode = 1'b0;
    send(1, 2'b11);
    send(0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      en = 1'b0; start = 1'b1; x = 2'b11;
      tick();
      vecs++;
      if ({bit_cnt, z, busy, abort} !== {3'd2, 2'b10, 1'b1, 1'b0}) begin
        errs++; $display("FAIL en_hold_%0d got cnt=%0d z=%b busy=%b abort=%b want 2 10 1 0", i, bit_cnt, z, busy, abort);
      end
    end
    start = 1'b0;
    send(0, 2'b00);
    send(0, 2'b01);
    vecs++;
    if ({bit_cnt, z} !== {3'd4, 2'b11}) begin
      errs++; $display("FAIL en_resume got cnt=%0d z=%b want 4 11", bit_cnt, z);
    end
    send(0, 2'b01);
    if (done) ndone++;
    vecs++;
    if (perr !== 2'b10) begin
      errs++; $display("FAIL en_hold_result got err=%b want 10", perr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) ndone++;
    end
    vecs++;
    if (ndone != 1) begin
      errs++; $display("FAIL en_hold_done_count got %0d want 1", ndone);
    end
  endtask

  task automatic test_abort();
    odd_mode = 1'b0;
    send(1, 2'b11);
    send(0, 2'b11);
    odd_mode = 1'b1;
    send(1, 2'b01);
    vecs++;
    if ({abort, done, bit_cnt, z, perr, busy} !== {1'b1, 1'b0, 3'd1, 2'b01, 2'b10, 1'b1}) begin
      errs++; $display("FAIL abort_pulse got abort=%b done=%b cnt=%0d z=%b err=%b busy=%b want 1 0 1 01 10 1", abort, done, bit_cnt, z, perr, busy);
    end
    odd_mode = 1'b0;
    send(0, 2'b11);
    vecs++;
    if ({abort, bit_cnt, z} !== {1'b0, 3'd2, 2'b10}) begin
      errs++; $display("FAIL abort_clear got abort=%b cnt=%0d z=%b want 0 2 10", abort, bit_cnt, z);
    end
    send(0, 2'b00);
    send(0, 2'b01);
    send(0, 2'b01);
    vecs++;
    if ({done, perr, z, abort} !== {1'b1, 2'b01, 2'b11, 1'b0}) begin
      errs++; $display("FAIL abort_new_frame got done=%b err=%b z=%b abort=%b want 1 01 11 0", done, perr, z, abort);
    end
    tick();
  endtask

  task automatic test_async_reset();
    odd_mode = 1'b1;
    send(1, 2'b11);
    send(0, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({z, bit_cnt, busy, done, perr, abort} !== 10'd0) begin
      errs++; $display("FAIL async_reset got %b want 0", {z, bit_cnt, busy, done, perr, abort});
    end
    tick();
    rst_n = 1'b1;
    tick();
    odd_mode = 1'b0;
    send(1, 2'b10);
    vecs++;
    if ({busy, bit_cnt, z, abort} !== {1'b1, 3'd1, 2'b10, 1'b0}) begin
      errs++; $display("FAIL post_reset_start got busy=%b cnt=%0d z=%b abort=%b want 1 1 10 0", busy, bit_cnt, z, abort);
    end
    send(0, 2'b10);
    send(0, 2'b00);
    send(0, 2'b00);
    send(0, 2'b10);
    vecs++;
    if ({done, perr, z} !== {1'b1, 2'b10, 2'b00}) begin
      errs++; $display("FAIL post_reset_frame got done=%b err=%b z=%b want 1 10 00", done, perr, z);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] dv [3];
    logic [1:0] pv [3];
    logic [1:0] ev [3];
    dv = '{2'b11, 2'b01, 2'b10};
    pv = '{2'b10, 2'b01, 2'b00};
    ev = '{2'b01, 2'b00, 2'b10};
    en2 = 1'b1; odd2 = 1'b0;
    for (int f = 0; f < 3; f++) begin
      start2 = 1'b1; x2 = dv[f];
      tick();
      vecs++;
      if ({busy2, bit_cnt2, z2, done2, abort2} !== {1'b1, 1'b1, dv[f], 1'b0, 1'b0}) begin
        errs++; $display("FAIL b2b_data_%0d got busy=%b cnt=%0d z=%b done=%b abort=%b want 1 1 %b 0 0", f, busy2, bit_cnt2, z2, done2, abort2, dv[f]);
      end
      start2 = 1'b0; x2 = pv[f];
      tick();
      vecs++;
      if ({done2, perr2, abort2, busy2} !== {1'b1, ev[f], 1'b0, 1'b0}) begin
        errs++; $display("FAIL b2b_check_%0d got done=%b err=%b abort=%b busy=%b want 1 %b 0 0", f, done2, perr2, abort2, busy2, ev[f]);
      end
    end
    en2 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_en_hold();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
